// File: rtl/led_pkg.sv
// Shared types and defaults for the LED breathing fader.
// The fade FSM encoding is visible on phase_o, so the values below are fixed.
package led_pkg;

  localparam int PWM_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HIGH = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LOW  = 2'd3
  } phase_e;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with a registered comparator driving the LED pin.
// The counter ignores enable; enable only gates the registered output.
module led_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [PWM_BITS-1:0] level_i,
  output logic                led_o
);

  logic [PWM_BITS-1:0] pwmCnt_q;
  logic                led_q;

  // Level 0 never beats the counter, so the LED is dark; MAX lights MAX of every 2^PWM_BITS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwmCnt_q <= '0;
      led_q    <= 1'b0;
    end else begin
      pwmCnt_q <= pwmCnt_q + PWM_BITS'(1);
      led_q    <= enable_i && (pwmCnt_q < level_i);
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_breath_fader.sv
// LED breathing fader: ramps brightness up and down on accepted ticks and drives PWM.
// Define LED_BREATH_HOLD_EN to add the HOLD_HIGH / HOLD_LOW dwell phases.
module led_breath_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEFAULT,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                enable_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic [1:0]          phase_o
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS:0]   STEP_EXT  = (PWM_BITS+1)'(STEP);

  if (PWM_BITS < 1 || STEP < 1 || STEP > (1 << PWM_BITS) - 1 || HOLD_TICKS < 1) begin : g_paramCheck
    $error("led_breath_fader: illegal PWM_BITS/STEP/HOLD_TICKS combination");
  end

  phase_e              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                accept;
  logic [PWM_BITS:0]   upSum;
  logic [PWM_BITS-1:0] levelUp;
  logic [PWM_BITS-1:0] levelDn;

`ifdef LED_BREATH_HOLD_EN
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic              holdDone;

  assign holdDone = (holdCnt_q == HOLD_W'(HOLD_TICKS - 1));
`endif

  // One extra bit keeps the saturating add and subtract free of wrap-around.
  assign accept  = tick_i & enable_i;
  assign upSum   = {1'b0, level_q} + STEP_EXT;
  assign levelUp = (upSum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : upSum[PWM_BITS-1:0];
  assign levelDn = ({1'b0, level_q} <= STEP_EXT) ? '0 : (level_q - STEP_EXT[PWM_BITS-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RAMP_UP;
      level_q   <= '0;
`ifdef LED_BREATH_HOLD_EN
      holdCnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
`ifdef LED_BREATH_HOLD_EN
      holdCnt_q <= holdCnt_d;
`endif
    end
  end

  // Without an accepted tick everything stays frozen, which is also how enable_i=0 pauses the fade.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
`ifdef LED_BREATH_HOLD_EN
    holdCnt_d = holdCnt_q;
`endif
    if (accept) begin
      case (state_q)
        RAMP_UP: begin
          level_d = levelUp;
          if (levelUp == LEVEL_MAX) begin
`ifdef LED_BREATH_HOLD_EN
            state_d = HOLD_HIGH;
`else
            state_d = RAMP_DOWN;
`endif
          end
        end
`ifdef LED_BREATH_HOLD_EN
        HOLD_HIGH: begin
          if (holdDone) begin
            holdCnt_d = '0;
            state_d   = RAMP_DOWN;
          end else begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
          end
        end
`endif
        RAMP_DOWN: begin
          level_d = levelDn;
          if (levelDn == '0) begin
`ifdef LED_BREATH_HOLD_EN
            state_d = HOLD_LOW;
`else
            state_d = RAMP_UP;
`endif
          end
        end
`ifdef LED_BREATH_HOLD_EN
        HOLD_LOW: begin
          if (holdDone) begin
            holdCnt_d = '0;
            state_d   = RAMP_UP;
          end else begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
          end
        end
`endif
        default: state_d = RAMP_UP;
      endcase
    end
  end

  always_comb begin
    phase_o = state_q;
    level_o = level_q;
  end

  led_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable_i),
    .level_i  (level_q),
    .led_o    (led_o)
  );

endmodule

// File: doc/led_breath_fader.md
LED_BREATH_FADER -- requirements
Module: led_breath_fader

Interface
REQ-001 Parameter PWM_BITS, default 8, sets the PWM counter and brightness level width.
REQ-002 Parameter STEP, default 1, sets the level change per accepted tick (1..2^PWM_BITS-1).
REQ-003 Parameter HOLD_TICKS, default 16, sets the accepted ticks spent in each hold phase (>=1).
REQ-004 Port clk, input, 1: sole clock, all logic rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port tick_i, input, 1: one-cycle strobe from the upstream clock divider that paces the fade.
REQ-007 Port enable_i, input, 1: run the fade when 1, freeze and blank it when 0.
REQ-008 Port led_o, output, 1: registered PWM drive to the LED pin.
REQ-009 Port level_o, output, PWM_BITS: current brightness level.
REQ-010 Port phase_o, output, 2: current FSM state, 0=RAMP_UP, 1=HOLD_HIGH, 2=RAMP_DOWN, 3=HOLD_LOW.

Function
REQ-011 The PWM counter shall be free-running, increment every clk, wrap from 2^PWM_BITS-1 to 0, and ignore enable_i.
REQ-012 led_o shall be registered as (pwm_cnt < level) AND enable_i: level 0 gives constantly off, level MAX gives on for MAX of every 2^PWM_BITS cycles.
REQ-013 Latency: a tick_i accepted in cycle n shall update level_o in n+1, and led_o shall reflect the new level from n+2.
REQ-014 A tick is accepted only when tick_i=1 and enable_i=1; the FSM and level shall not change in any other cycle.
REQ-015 In RAMP_UP, each accepted tick sets level to min(level+STEP, MAX), computed without overflow; when the result equals MAX, the FSM goes to HOLD_HIGH in the same cycle.
REQ-016 In HOLD_HIGH, the block counts accepted ticks; on the HOLD_TICKS-th it clears the count and goes to RAMP_DOWN, with level unchanged.
REQ-017 In RAMP_DOWN, each accepted tick sets level to max(level-STEP, 0) without underflow; when the result equals 0, the FSM goes to HOLD_LOW in the same cycle.
REQ-018 In HOLD_LOW, the block counts as in HOLD_HIGH; on the HOLD_TICKS-th accepted tick it goes to RAMP_UP.
REQ-019 enable_i=0 shall freeze state, level and hold count, and force led_o to 0 from the next cycle.
REQ-020 When enable_i returns to 1, the fade shall resume from the frozen point with no extra tick consumed.
REQ-021 When tick_i is held high for several cycles, each enabled cycle shall count as one accepted tick; edge detection is upstream's job.

Reset
REQ-022 While rst_n=0 the block shall hold: led_o=0, level_o=0, phase_o=RAMP_UP, hold count=0, PWM counter=0.
REQ-023 Reset asserted mid-fade shall abort immediately to the REQ-022 values; after deassertion the first accepted tick yields level=STEP.

Configuration
REQ-024 Macro LED_BREATH_HOLD_EN compiled in: HOLD_HIGH and HOLD_LOW shall exist as specified in REQ-016 and REQ-018.
REQ-025 LED_BREATH_HOLD_EN absent: reaching MAX shall go directly to RAMP_DOWN and reaching 0 directly to RAMP_UP; phase_o shall only take values 0 and 2; the hold counter and HOLD_TICKS logic shall not be synthesised.

Structure
REQ-026 Package led_pkg shall hold the FSM state enum (encodings per REQ-010) and the PWM_BITS default constant.
REQ-027 Sub-module led_pwm shall contain the free-running counter and the registered comparator producing led_o; led_breath_fader shall instantiate it once.

Verification (PWM_BITS=4, STEP=4, HOLD_TICKS=2, macro defined unless stated)
REQ-028 Reset release, 5 accepted ticks -> level_o sequence 4,8,12,15 (saturated); phase_o goes to 1 on the 4th tick; the 5th tick leaves level_o at 15.
REQ-029 Level 8 held, observe 32 cycles -> led_o high exactly 8 of each 16 cycles; first high appears 2 cycles after the tick that set 8.
REQ-030 Full cycle under periodic ticks -> phase_o sequence 0,1,2,3,0; level_o falls 15,11,7,3,0.
REQ-031 enable_i=0 for 20 cycles with ticks present -> led_o=0, level_o and phase_o unchanged; after re-enable the next tick advances exactly one step.
REQ-032 rst_n pulsed low mid-RAMP_DOWN at level 7 -> outputs at reset values asynchronously; after release the next tick gives level_o=4, phase_o=0.
REQ-033 Macro undefined, ramp to 15 -> the tick producing 15 sets phase_o=2, and the next tick gives level_o=11.
